// File: rtl/seg_scan_display.sv
// seg_scan_display: multi-channel binary-to-decimal display driver.
//   Converts each channel value to BCD with an iterative double-dabble engine,
//   serviced round-robin. It time-multiplexes every digit of every channel onto
//   one active-low seven-segment bus that has active-low one-hot digit enables.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = in reset)
//   in_val     NCH packed channel values, channel c = in_val[c*WIDTH +: WIDTH]
//   hold       freeze display contents once the in-flight conversion commits
//   seg        segments a..g on bits 0..6, active-low, registered
//   dig_en     one-hot active-low digit enable, index c*NDIG + d, registered
//   ovf        per-channel flag: latched value >= 10^NDIG
//   conv_done  one-cycle pulse while a channel result commits
//   conv_ch    channel being committed, valid with conv_done (0 otherwise)
// Timing: LOAD to conv_done takes WIDTH+1 cycles. A full refresh of all
//   channels takes NCH*(WIDTH+2) cycles. seg/dig_en lag the scan index by one
//   cycle.

module seg_scan_display #(
  parameter int NCH      = 3,
  parameter int WIDTH    = 8,
  parameter int NDIG     = 3,
  parameter int SCAN_DIV = 1024,
  parameter int BLANK    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NCH*WIDTH-1:0]                   in_val,
  input  logic                                   hold,
  output logic [6:0]                             seg,
  output logic [NCH*NDIG-1:0]                    dig_en,
  output logic [NCH-1:0]                         ovf,
  output logic                                   conv_done,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] conv_ch
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NIDX = NCH * NDIG;
  localparam int IDXW = (NIDX > 1) ? $clog2(NIDX) : 1;
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int BW   = NDIG * 4;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Values at or above this limit do not fit in NDIG decimal digits.
  localparam logic [63:0] OVF_LIM = pow10(NDIG);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT,
    S_COMMIT,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Conversion engine state
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CHW-1:0]    r_ptr;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_bcd;
  logic [CNTW-1:0]   r_cnt;
  logic              r_ovf_nxt;

  // Committed per-channel results
  logic [NIDX*4-1:0] r_digits;
  logic [NCH-1:0]    r_ovf;
  logic [NCH-1:0]    r_valid;   // channel has committed at least once since reset

  // Scan state
  logic [PW-1:0]     r_pre;
  logic [IDXW-1:0]   r_idx;
  logic [6:0]        r_seg;
  logic [NIDX-1:0]   r_dig_en;

  logic [WIDTH-1:0]  w_ld_val;
  logic [BW-1:0]     w_bcd_adj;
  logic [6:0]        w_seg_all [NIDX];
  logic [6:0]        w_seg_sel;
  logic [NIDX-1:0]   w_dig_nxt;

  // Channel mux for the value sampled in LOAD.
  always_comb begin
    w_ld_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_ptr == CHW'(c)) w_ld_val = in_val[c*WIDTH +: WIDTH];
    end
  end

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so that
  // it carries into the next decade once doubled.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < NDIG; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5) w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state / output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    conv_done   = 1'b0;
    conv_ch     = '0;
    case (r_state)
      S_LOAD:   w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == CNTW'(WIDTH - 1)) w_state_nxt = S_COMMIT;
      S_COMMIT: begin
        conv_done   = 1'b1;
        conv_ch     = r_ptr;
        w_state_nxt = hold ? S_HOLD : S_LOAD;
      end
      S_HOLD:   if (!hold) w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath and result commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_nxt <= 1'b0;
      r_digits  <= '0;
      r_ovf     <= '0;
      r_valid   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_bin     <= w_ld_val;
          r_bcd     <= '0;
          r_cnt     <= '0;
          r_ovf_nxt <= (64'(w_ld_val) >= OVF_LIM);
        end
        S_SHIFT: begin
          // Shift {bcd, bin} left by one; the carry out of the top nibble is
          // dropped because out-of-range values are reported through ovf.
          r_bcd <= {w_bcd_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
        end
        S_COMMIT: begin
          for (int c = 0; c < NCH; c++) begin
            if (r_ptr == CHW'(c)) begin
              r_digits[c*BW +: BW] <= r_bcd;
              r_ovf[c]             <= r_ovf_nxt;
              r_valid[c]           <= 1'b1;
            end
          end
          r_ptr <= (r_ptr == CHW'(NCH - 1)) ? '0 : r_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit segment decode
  // ---------------------------------------------------------------------------
  for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
    for (genvar gd = 0; gd < NDIG; gd++) begin : g_dig
      localparam int K = gc * NDIG + gd;
      logic [3:0] w_nib;
      logic       w_upper_zero;
      assign w_nib        = r_digits[K*4 +: 4];
      // This digit and every more significant digit of the channel are zero.
      assign w_upper_zero = (r_digits[gc*BW + gd*4 +: (NDIG-gd)*4] == '0);
      assign w_seg_all[K] = !r_valid[gc]                           ? 7'h7F :
                            r_ovf[gc]                              ? 7'b0111111 :
                            ((BLANK != 0) && (gd > 0) && w_upper_zero) ? 7'h7F :
                                                                     seg7(w_nib);
    end
  end

  always_comb begin
    w_seg_sel = 7'h7F;
    w_dig_nxt = '1;
    for (int k = 0; k < NIDX; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_seg_sel    = w_seg_all[k];
        w_dig_nxt[k] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler, index and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_seg    <= 7'h7F;
      r_dig_en <= '1;
    end else begin
      if (r_pre == PW'(SCAN_DIV - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDXW'(NIDX - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      // Segments and enable update together from one registered decode, so
      // a commit on the scanned channel shows up cleanly on the next cycle.
      r_seg    <= w_seg_sel;
      r_dig_en <= w_dig_nxt;
    end
  end

  assign seg    = r_seg;
  assign dig_en = r_dig_en;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display: two instances (leading-zero blanking on/off)
// share stimulus; expected segments come from a decimal model of the latched
// channel values.
module tb_seg_scan_display;

  localparam int NCH   = 3;
  localparam int WIDTH = 10;
  localparam int NDIG  = 3;
  localparam int SD    = 4;
  localparam int NIDX  = NCH * NDIG;
  localparam int CONV  = WIDTH + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 hold = 1'b0;
  logic [NCH*WIDTH-1:0] in_val = '0;

  logic [6:0]      seg_b, seg_z;
  logic [NIDX-1:0] dig_b, dig_z;
  logic [NCH-1:0]  ovf_b, ovf_z;
  logic            done_b, done_z;
  logic [1:0]      ch_b, ch_z;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: last value each channel displays, and whether it has one.
  int mval   [NCH];
  bit mvalid [NCH];

  seg_scan_display #(.NCH(NCH), .WIDTH(WIDTH), .NDIG(NDIG), .SCAN_DIV(SD), .BLANK(1)) dut_b (
    .clk(clk), .rst(rst), .in_val(in_val), .hold(hold), .seg(seg_b), .dig_en(dig_b),
    .ovf(ovf_b), .conv_done(done_b), .conv_ch(ch_b));

  seg_scan_display #(.NCH(NCH), .WIDTH(WIDTH), .NDIG(NDIG), .SCAN_DIV(SD), .BLANK(0)) dut_z (
    .clk(clk), .rst(rst), .in_val(in_val), .hold(hold), .seg(seg_z), .dig_en(dig_z),
    .ovf(ovf_z), .conv_done(done_z), .conv_ch(ch_z));

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int c, input int d, input bit blank);
    int v;
    int pw;
    v  = mval[c];
    pw = 1;
    for (int i = 0; i < d; i++) pw = pw * 10;
    if (!mvalid[c]) return 7'h7F;
    if (v >= 1000) return 7'b0111111;
    if (blank && d > 0 && v < pw) return 7'h7F;
    case ((v / pw) % 10)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [NCH-1:0] exp_ovf();
    logic [NCH-1:0] o;
    for (int c = 0; c < NCH; c++) o[c] = mvalid[c] && (mval[c] >= 1000);
    return o;
  endfunction

  task automatic model_latch();
    for (int c = 0; c < NCH; c++) begin
      mval[c]   = int'(in_val[c*WIDTH +: WIDTH]);
      mvalid[c] = 1'b1;
    end
  endtask

  // Advance to the first sample where digit k is enabled; ok=0 on timeout.
  task automatic wait_idx(input int k, output bit ok);
    logic [NIDX-1:0] want;
    want = ~(NIDX'(1) << k);
    ok = 1'b0;
    for (int i = 0; i < 4 * NIDX * SD && !ok; i++) begin
      @(negedge clk);
      if (dig_b === want) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (seg_b !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg_b); end
    n_tests++; if (dig_b !== 9'h1FF) begin n_fail++; $display("FAIL reset_dig got %h want 1ff", dig_b); end
    n_tests++; if (ovf_b !== 3'b000) begin n_fail++; $display("FAIL reset_ovf got %b want 000", ovf_b); end
    n_tests++; if (done_b !== 1'b0 || ch_b !== 2'd0) begin n_fail++; $display("FAIL reset_done got %b/%0d want 0/0", done_b, ch_b); end
    n_tests++; if (seg_z !== 7'h7F || dig_z !== 9'h1FF) begin n_fail++; $display("FAIL reset_z got %h/%h want 7f/1ff", seg_z, dig_z); end
    for (int c = 0; c < NCH; c++) mvalid[c] = 1'b0;
  endtask

  task automatic test_first_conv();
    int  edge_at [3];
    int  ch_at   [3];
    int  seen;
    bit  ok;
    seen   = 0;
    in_val = {10'd0, 10'd7, 10'd123};
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 3 * CONV + 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        n_tests++;
        if (dig_b !== 9'h1FE || seg_b !== 7'h7F) begin
          n_fail++; $display("FAIL blank_before_commit got %h/%h want 1fe/7f", dig_b, seg_b);
        end
      end
      if (done_b && seen < 3) begin
        edge_at[seen] = n;
        ch_at[seen]   = int'(ch_b);
        seen++;
      end
    end
    n_tests++; if (seen != 3) begin n_fail++; $display("FAIL first_commits got %0d want 3", seen); end
    for (int i = 0; i < seen; i++) begin
      n_tests++;
      if (edge_at[i] != WIDTH + 1 + i * CONV || ch_at[i] != i) begin
        n_fail++;
        $display("FAIL commit_%0d got cycle %0d ch %0d want cycle %0d ch %0d", i, edge_at[i], ch_at[i], WIDTH + 1 + i * CONV, i);
      end
    end
    model_latch();
    for (int k = 0; k < NIDX; k++) begin
      wait_idx(k, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL first_idx%0d timeout", k); end
      else begin
        n_tests++; if (seg_b !== exp_seg(k / NDIG, k % NDIG, 1)) begin n_fail++; $display("FAIL first_seg_b idx%0d got %b want %b", k, seg_b, exp_seg(k / NDIG, k % NDIG, 1)); end
        n_tests++; if (seg_z !== exp_seg(k / NDIG, k % NDIG, 0)) begin n_fail++; $display("FAIL first_seg_z idx%0d got %b want %b", k, seg_z, exp_seg(k / NDIG, k % NDIG, 0)); end
      end
    end
  endtask

  task automatic test_scan_timing();
    bit ok;
    logic [NIDX-1:0] want;
    wait_idx(NIDX - 1, ok);
    if (ok) wait_idx(0, ok);  // first cycle of idx0 dwell
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL scan_sync timeout"); end
    else begin
      for (int t = 0; t < 40; t++) begin
        want = ~(NIDX'(1) << ((t / SD) % NIDX));
        n_tests++;
        if (dig_b !== want || dig_z !== want) begin
          n_fail++; $display("FAIL scan_t%0d got %h want %h", t, dig_b, want);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      in_val[2*WIDTH +: WIDTH] = (pass == 0) ? 10'd1000 : 10'd999;
      repeat (2 * NCH * CONV + 8) @(negedge clk);
      model_latch();
      n_tests++;
      if (ovf_b !== exp_ovf() || ovf_z !== exp_ovf()) begin
        n_fail++; $display("FAIL ovf_pass%0d got %b want %b", pass, ovf_b, exp_ovf());
      end
      for (int k = 0; k < NIDX; k++) begin
        wait_idx(k, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ovf_idx%0d timeout", k); end
        else begin
          n_tests++; if (seg_b !== exp_seg(k / NDIG, k % NDIG, 1)) begin n_fail++; $display("FAIL ovf_seg_b idx%0d got %b want %b", k, seg_b, exp_seg(k / NDIG, k % NDIG, 1)); end
          n_tests++; if (seg_z !== exp_seg(k / NDIG, k % NDIG, 0)) begin n_fail++; $display("FAIL ovf_seg_z idx%0d got %b want %b", k, seg_z, exp_seg(k / NDIG, k % NDIG, 0)); end
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 5))
          0:       in_val[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
          1:       in_val[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(995, 1005));
          default: in_val[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 1023));
        endcase
      end
      repeat (2 * NCH * CONV + 8) @(negedge clk);
      model_latch();
      n_tests++;
      if (ovf_b !== exp_ovf()) begin n_fail++; $display("FAIL rand%0d_ovf got %b want %b", r, ovf_b, exp_ovf()); end
      for (int k = 0; k < NIDX; k++) begin
        wait_idx(k, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rand%0d_idx%0d timeout", r, k); end
        else begin
          n_tests++; if (seg_b !== exp_seg(k / NDIG, k % NDIG, 1)) begin n_fail++; $display("FAIL rand%0d_seg_b idx%0d got %b want %b", r, k, seg_b, exp_seg(k / NDIG, k % NDIG, 1)); end
          n_tests++; if (seg_z !== exp_seg(k / NDIG, k % NDIG, 0)) begin n_fail++; $display("FAIL rand%0d_seg_z idx%0d got %b want %b", r, k, seg_z, exp_seg(k / NDIG, k % NDIG, 0)); end
        end
      end
    end
  endtask

  task automatic test_hold();
    bit got;
    bit ok;
    int extra;
    in_val = {10'd42, 10'd5, 10'd1000};
    repeat (2 * NCH * CONV + 8) @(negedge clk);
    model_latch();
    got = 1'b0;
    for (int i = 0; i < 2 * NCH * CONV && !got; i++) begin
      @(negedge clk);
      if (done_b && ch_b == 2'd0) got = 1'b1;
    end
    n_tests++; if (!got) begin n_fail++; $display("FAIL hold_sync timeout waiting ch0 commit"); end
    repeat (3) @(negedge clk);   // now inside the SHIFT phase of channel 1
    hold = 1'b1;
    got = 1'b0;
    for (int i = 0; i < CONV + 4 && !got; i++) begin
      @(negedge clk);
      if (done_b) got = 1'b1;
    end
    n_tests++;
    if (!got || ch_b !== 2'd1) begin n_fail++; $display("FAIL hold_commit got done=%b ch=%0d want 1/1", got, ch_b); end
    in_val = {10'd871, 10'd360, 10'd24};
    extra = 0;
    for (int i = 0; i < 2 * NCH * CONV; i++) begin
      @(negedge clk);
      if (done_b) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL hold_quiet got %0d commits want 0", extra); end
    n_tests++; if (ovf_b !== exp_ovf()) begin n_fail++; $display("FAIL hold_ovf got %b want %b", ovf_b, exp_ovf()); end
    for (int k = 0; k < NIDX; k++) begin
      wait_idx(k, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL hold_idx%0d timeout", k); end
      else begin
        n_tests++; if (seg_b !== exp_seg(k / NDIG, k % NDIG, 1)) begin n_fail++; $display("FAIL hold_seg_b idx%0d got %b want %b", k, seg_b, exp_seg(k / NDIG, k % NDIG, 1)); end
      end
    end
    hold = 1'b0;
    got = 1'b0;
    for (int i = 0; i < CONV + 4 && !got; i++) begin
      @(negedge clk);
      if (done_b) got = 1'b1;
    end
    n_tests++;
    if (!got || ch_b !== 2'd2) begin n_fail++; $display("FAIL hold_release got done=%b ch=%0d want 1/2", got, ch_b); end
  endtask

  task automatic test_async_reset();
    bit got;
    int lat;
    in_val = {10'd1000, 10'd55, 10'd9};
    repeat (2 * NCH * CONV + 8) @(negedge clk);
    model_latch();
    n_tests++; if (ovf_b !== 3'b100) begin n_fail++; $display("FAIL pre_reset_ovf got %b want 100", ovf_b); end
    got = 1'b0;
    for (int i = 0; i < 2 * NCH * CONV && !got; i++) begin
      @(negedge clk);
      if (done_b && ch_b == 2'd0) got = 1'b1;
    end
    n_tests++; if (!got) begin n_fail++; $display("FAIL areset_sync timeout waiting ch0 commit"); end
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (seg_b !== 7'h7F || seg_z !== 7'h7F) begin n_fail++; $display("FAIL areset_seg got %h want 7f", seg_b); end
    n_tests++; if (dig_b !== 9'h1FF || dig_z !== 9'h1FF) begin n_fail++; $display("FAIL areset_dig got %h want 1ff", dig_b); end
    n_tests++; if (ovf_b !== 3'b000) begin n_fail++; $display("FAIL areset_ovf got %b want 000", ovf_b); end
    n_tests++; if (done_b !== 1'b0 || ch_b !== 2'd0) begin n_fail++; $display("FAIL areset_done got %b/%0d want 0/0", done_b, ch_b); end
    for (int c = 0; c < NCH; c++) mvalid[c] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= CONV + 4 && !got; n++) begin
      @(negedge clk);
      if (done_b) begin got = 1'b1; lat = n; end
    end
    n_tests++;
    if (!got || ch_b !== 2'd0 || lat != WIDTH + 1) begin
      n_fail++; $display("FAIL areset_first got ch=%0d cycle=%0d want ch 0 cycle %0d", ch_b, lat, WIDTH + 1);
    end
  endtask

  initial begin
    test_reset();
    test_first_conv();
    test_scan_timing();
    test_overflow();
    test_random();
    test_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
